// File: rtl/crp16_io_bridge_if.sv
// crp16_io_bridge_if: bus bundle between the CRP16 datapath port B, its RAM and the output FIFO consumer
//   cpu_addr/cpu_wdata/cpu_wren  datapath port-B request, cpu_rdata  read data back to the datapath
//   ram_addr/ram_wdata/ram_wren  forwarded RAM port-B request, ram_q  RAM asynchronous read data
//   out_data/out_valid           FIFO head word and non-empty flag, out_ready  consumer accept
//   master: the environment (datapath, RAM, consumer); slave: the bridge
interface crp16_io_bridge_if;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_wren;
    logic [15:0] cpu_rdata;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_wren;
    logic [15:0] ram_q;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    modport master (
        output cpu_addr, cpu_wdata, cpu_wren, ram_q, out_ready,
        input  cpu_rdata, ram_addr, ram_wdata, ram_wren, out_data, out_valid
    );
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wren, ram_q, out_ready,
        output cpu_rdata, ram_addr, ram_wdata, ram_wren, out_data, out_valid
    );
endinterface

// File: rtl/crp16_io_bridge.sv
// crp16_io_bridge: splits datapath port B between RAM and a page of I/O registers (LED, switches, output FIFO, timer)
//   clock    system clock, rising edge
//   resetn   asynchronous active-low reset
//   bus      crp16_io_bridge_if.slave: CPU port, RAM port and FIFO output stream
//   sw_in    raw asynchronous switch inputs
//   led_out  LED register contents
// I/O register map (high address byte == IO_PAGE, low byte):
//   0 LED  1 SW  2 FIFO_DATA  3 FIFO_STAT  4 TIMER  5 TIMER_CMP  6 TIMER_FLAG  others read 0
module crp16_io_bridge #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] IO_PAGE    = 8'hFF
) (
    input  logic                clock,
    input  logic                resetn,
    crp16_io_bridge_if.slave    bus,
    input  logic [15:0]         sw_in,
    output logic [15:0]         led_out
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic          hit;
    logic [7:0]    reg_off;
    logic          io_wr;
    logic          wr_led, wr_fifo, wr_stat, wr_timer, wr_cmp, wr_flag;
    logic [15:0]   led;
    logic [15:0]   sw_meta, sw_sync;
    logic [15:0]   timer, timer_cmp;
    logic          match;
    logic          overflow;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [4:0]    count;
    logic [15:0]   mem [FIFO_DEPTH];
    logic          full, empty, pop, accept;
    logic [15:0]   io_rdata;

    // Decoding uses the whole low byte so offsets with cpu_addr[7:4] != 0 never match a register.
    assign hit      = bus.cpu_addr[15:8] == IO_PAGE;
    assign reg_off  = bus.cpu_addr[7:0];
    assign io_wr    = bus.cpu_wren & hit;
    assign wr_led   = io_wr && reg_off == 8'h00;
    assign wr_fifo  = io_wr && reg_off == 8'h02;
    assign wr_stat  = io_wr && reg_off == 8'h03;
    assign wr_timer = io_wr && reg_off == 8'h04;
    assign wr_cmp   = io_wr && reg_off == 8'h05;
    assign wr_flag  = io_wr && reg_off == 8'h06;

    assign bus.ram_addr  = bus.cpu_addr;
    assign bus.ram_wdata = bus.cpu_wdata;
    assign bus.ram_wren  = bus.cpu_wren & ~hit;

    assign full   = count == 5'(FIFO_DEPTH);
    assign empty  = count == 5'd0;
    assign pop    = ~empty & bus.out_ready;
    // A push at full is still taken when the head leaves in the same cycle.
    assign accept = wr_fifo & (~full | pop);

    assign bus.out_valid = ~empty;
    assign bus.out_data  = mem[rd_ptr];
    assign led_out       = led;

    always_comb begin
        io_rdata = 16'h0000;
        case (reg_off)
            8'h00:   io_rdata = led;
            8'h01:   io_rdata = sw_sync;
            8'h03:   io_rdata = {8'h00, count, overflow, empty, full};
            8'h04:   io_rdata = timer;
            8'h05:   io_rdata = timer_cmp;
            8'h06:   io_rdata = {15'h0000, match};
            default: io_rdata = 16'h0000;
        endcase
    end

    assign bus.cpu_rdata = hit ? io_rdata : bus.ram_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            led       <= 16'h0000;
            sw_meta   <= 16'h0000;
            sw_sync   <= 16'h0000;
            timer     <= 16'h0000;
            timer_cmp <= 16'h0000;
            match     <= 1'b0;
            overflow  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= 5'd0;
        end else begin
            if (wr_led)
                led <= bus.cpu_wdata;
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            timer   <= wr_timer ? bus.cpu_wdata : timer + 16'd1;
            if (wr_cmp)
                timer_cmp <= bus.cpu_wdata;
            // A compare hit outranks a clear written in the same cycle.
            match    <= (timer == timer_cmp) | (match & ~(wr_flag & bus.cpu_wdata[0]));
            overflow <= (wr_fifo & full & ~pop) | (overflow & ~wr_stat);
            if (accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + 5'(accept) - 5'(pop);
        end
    end

    // Storage is not reset; a held reset blocks writes so nothing lands behind a cleared pointer.
    always_ff @(posedge clock) begin
        if (accept && resetn)
            mem[wr_ptr] <= bus.cpu_wdata;
    end
endmodule

// File: tb/tb_crp16_io_bridge.sv
// tb_crp16_io_bridge: directed and random checks of crp16_io_bridge against a queue-based reference model
module tb_crp16_io_bridge;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] sw_in = 16'h0000;
    logic [15:0] led_out;

    crp16_io_bridge_if bus ();

    crp16_io_bridge #(.FIFO_DEPTH(DEPTH), .IO_PAGE(8'hFF)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus),
        .sw_in  (sw_in),
        .led_out(led_out)
    );

    always #5 clock = ~clock;

    logic [15:0] env_ram [256];
    assign bus.ram_q = env_ram[bus.ram_addr[7:0]];

    int tests = 0;
    int fails = 0;

    logic [15:0] m_led, m_timer, m_cmp, m_sw1, m_sw2;
    logic        m_match, m_ovf;
    logic [15:0] m_q [$];
    logic [15:0] m_ram [256];

    logic [15:0] a = 16'h0000, d = 16'h0000, sw_nx = 16'h0000;
    logic        we = 1'b0, rdy = 1'b0, rst_nx = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_led = 0; m_timer = 0; m_cmp = 0; m_sw1 = 0; m_sw2 = 0;
        m_match = 0; m_ovf = 0;
        m_q.delete();
    endtask

    function automatic logic [15:0] m_rdata(input logic [15:0] ad);
        if (ad[15:8] != 8'hFF) return m_ram[ad[7:0]];
        case (ad[7:0])
            8'h00: return m_led;
            8'h01: return m_sw2;
            8'h03: return {8'h00, 5'(m_q.size()), m_ovf, m_q.size() == 0, m_q.size() == DEPTH};
            8'h04: return m_timer;
            8'h05: return m_cmp;
            8'h06: return {15'h0000, m_match};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check_all();
        chk("ram_addr", bus.ram_addr, a);
        chk("ram_wdata", bus.ram_wdata, d);
        chk("ram_wren", 16'(bus.ram_wren), 16'(we && a[15:8] != 8'hFF));
        chk("cpu_rdata", bus.cpu_rdata, m_rdata(a));
        chk("led_out", led_out, m_led);
        chk("out_valid", 16'(bus.out_valid), 16'(m_q.size() != 0));
        if (m_q.size() != 0) chk("out_data", bus.out_data, m_q[0]);
    endtask

    task automatic m_next();
        logic hit, iw, pop, full, nmatch;
        hit = a[15:8] == 8'hFF;
        iw  = we & hit;
        if (we && !hit) m_ram[a[7:0]] = d;
        if (!resetn) begin
            m_reset();
            return;
        end
        pop    = m_q.size() != 0 && rdy;
        full   = m_q.size() == DEPTH;
        nmatch = (m_timer == m_cmp) || (m_match && !(iw && a[7:0] == 8'h06 && d[0]));
        if (pop) void'(m_q.pop_front());
        if (iw && a[7:0] == 8'h02) begin
            if (!full || pop) m_q.push_back(d);
            else m_ovf = 1;
        end
        if (iw && a[7:0] == 8'h03) m_ovf = 0;
        m_timer = (iw && a[7:0] == 8'h04) ? d : m_timer + 16'd1;
        if (iw && a[7:0] == 8'h00) m_led = d;
        if (iw && a[7:0] == 8'h05) m_cmp = d;
        m_match = nmatch;
        m_sw2 = m_sw1;
        m_sw1 = sw_in;
    endtask

    task automatic step(input logic [15:0] na, input logic [15:0] nd, input logic nwe, input logic nrdy);
        @(negedge clock);
        a = na; d = nd; we = nwe; rdy = nrdy;
        bus.cpu_addr = na; bus.cpu_wdata = nd; bus.cpu_wren = nwe; bus.out_ready = nrdy;
        sw_in = sw_nx;
        resetn = rst_nx;
        #1;
        check_all();
        if (bus.ram_wren) env_ram[bus.ram_addr[7:0]] = bus.ram_wdata;
        m_next();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("async_led", led_out, 16'h0000);
        chk("async_valid", 16'(bus.out_valid), 16'h0000);
        m_reset();
        rst_nx = 1'b0;
        idle(2);
        rst_nx = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_ram[i] = 16'(i * 16'h0101);
            m_ram[i]   = 16'(i * 16'h0101);
        end
        bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_wren = 0; bus.out_ready = 0;
        m_reset();
        idle(2);
        chk("reset_led", led_out, 16'h0000);
        chk("reset_valid", 16'(bus.out_valid), 16'h0000);
        rst_nx = 1'b1;
        step(16'hFF04, 16'h0000, 1'b0, 1'b0);
        chk("timer_first", bus.cpu_rdata, 16'h0000);
        step(16'hFF04, 16'h0000, 1'b0, 1'b0);
        chk("timer_second", bus.cpu_rdata, 16'h0001);

        step(16'h0040, 16'h1234, 1'b1, 1'b0);
        chk("ram_wren_miss", 16'(bus.ram_wren), 16'h0001);
        step(16'h0040, 16'h0000, 1'b0, 1'b0);
        chk("ram_readback", bus.cpu_rdata, 16'h1234);

        step(16'hFF00, 16'hA5A5, 1'b1, 1'b0);
        chk("ram_wren_io", 16'(bus.ram_wren), 16'h0000);
        step(16'hFF00, 16'h0000, 1'b0, 1'b0);
        chk("led_write", led_out, 16'hA5A5);
        chk("led_read", bus.cpu_rdata, 16'hA5A5);
        sw_nx = 16'h00FF;
        step(16'hFF01, 16'h0000, 1'b0, 1'b0);
        step(16'hFF01, 16'h0000, 1'b0, 1'b0);
        chk("sw_one_edge", bus.cpu_rdata, 16'h0000);
        step(16'hFF01, 16'h0000, 1'b0, 1'b0);
        chk("sw_two_edges", bus.cpu_rdata, 16'h00FF);

        for (int i = 1; i <= 9; i++) step(16'hFF02, 16'(16'h0100 + i), 1'b1, 1'b0);
        step(16'hFF03, 16'h0000, 1'b0, 1'b0);
        chk("stat_overflow", bus.cpu_rdata, 16'h0045);
        step(16'h0000, 16'h0000, 1'b0, 1'b1);
        chk("first_word", bus.out_data, 16'h0101);
        for (int i = 0; i < 7; i++) step(16'h0000, 16'h0000, 1'b0, 1'b1);
        step(16'hFF03, 16'h0000, 1'b1, 1'b0);
        chk("stat_drained", bus.cpu_rdata, 16'h0006);
        step(16'hFF03, 16'h0000, 1'b0, 1'b0);
        chk("stat_cleared", bus.cpu_rdata, 16'h0002);

        for (int i = 1; i <= 8; i++) step(16'hFF02, 16'(16'h0200 + i), 1'b1, 1'b0);
        step(16'hFF02, 16'h02FF, 1'b1, 1'b1);
        step(16'hFF03, 16'h0000, 1'b0, 1'b0);
        chk("stat_full_pushpop", bus.cpu_rdata, 16'h0041);
        for (int i = 0; i < 8; i++) step(16'h0000, 16'h0000, 1'b0, 1'b1);

        step(16'hFF04, 16'hFFFE, 1'b1, 1'b0);
        step(16'hFF05, 16'h0001, 1'b1, 1'b0);
        step(16'hFF06, 16'h0001, 1'b1, 1'b0);
        step(16'hFF04, 16'h0000, 1'b0, 1'b0);
        chk("timer_wrap", bus.cpu_rdata, 16'h0000);
        step(16'hFF06, 16'h0001, 1'b1, 1'b0);
        chk("match_before", bus.cpu_rdata, 16'h0000);
        step(16'hFF06, 16'h0000, 1'b0, 1'b0);
        chk("match_set_wins", bus.cpu_rdata, 16'h0001);

        for (int i = 1; i <= 3; i++) step(16'hFF02, 16'(16'h0300 + i), 1'b1, 1'b0);
        step(16'hFF00, 16'hFFFF, 1'b1, 1'b0);
        step(16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("led_all_on", led_out, 16'hFFFF);
        async_reset();
        step(16'hFF03, 16'h0000, 1'b0, 1'b0);
        chk("stat_after_reset", bus.cpu_rdata, 16'h0002);

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ra, rd;
            ra[15:8] = ($urandom_range(0, 9) < 7) ? 8'hFF : 8'($urandom);
            ra[7:0]  = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            rd       = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            if ($urandom_range(0, 7) == 0) sw_nx = 16'($urandom);
            if ($urandom_range(0, 599) == 0) async_reset();
            step(ra, rd, $urandom_range(0, 2) != 0, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
